// File: rtl/swap_sequencer.sv
// swap_sequencer: ID-stage sequencer that splits a SWP instruction into two
// micro-ops (FIRST then SECOND), freezing IF/ID for the FIRST cycle only,
// honouring hazard stalls and branch flushes, and counting completed swaps.
module swap_sequencer #(
    parameter logic [5:0] SWP_OPCODE = 6'b111111,
    parameter logic [3:0] CMD_FIRST  = 4'b1100,
    parameter logic [3:0] CMD_SECOND = 4'b1101,
    parameter int         CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             id_valid,
    input  logic             hazard_stall,
    input  logic             flush,
    output logic             freeze,
    output logic [1:0]       swp_sel,
    output logic [3:0]       uop_cmd,
    output logic             uop_valid,
    output logic             uop_wb_en,
    output logic             busy,
    output logic [CNT_W-1:0] swp_count
);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_SECOND     = 2'd1,
        S_HOLD_FIRST = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_count;
    logic             w_trig;
    logic             w_issue_first;
    logic             w_issue_second;

    // A flushed instruction in ID is never a SWP candidate.
    assign w_trig = id_valid & (opcode == SWP_OPCODE) & ~flush;

    // FIRST issues either straight from IDLE or once a held SWP is released.
    assign w_issue_first  = ((r_state == S_IDLE) & w_trig & ~hazard_stall) |
                            ((r_state == S_HOLD_FIRST) & ~flush & ~hazard_stall);
    assign w_issue_second = (r_state == S_SECOND) & ~flush & ~hazard_stall;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; flush takes priority over hazard_stall everywhere.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_trig) begin
                    w_next = hazard_stall ? S_HOLD_FIRST : S_SECOND;
                end
            end
            S_HOLD_FIRST: begin
                if (flush) begin
                    w_next = S_IDLE;
                end else if (!hazard_stall) begin
                    w_next = S_SECOND;
                end
            end
            S_SECOND: begin
                if (flush || !hazard_stall) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Mealy outputs; everything is held at zero while reset is asserted.
    always_comb begin
        freeze    = 1'b0;
        swp_sel   = 2'b00;
        uop_cmd   = 4'b0000;
        uop_valid = 1'b0;
        uop_wb_en = 1'b0;
        busy      = 1'b0;
        swp_count = '0;
        if (!rst) begin
            busy      = (r_state != S_IDLE);
            swp_count = r_count;
            if (w_issue_first) begin
                freeze    = 1'b1;
                swp_sel   = 2'b01;
                uop_cmd   = CMD_FIRST;
                uop_valid = 1'b1;
                uop_wb_en = 1'b1;
            end else if (w_issue_second) begin
                swp_sel   = 2'b10;
                uop_cmd   = CMD_SECOND;
                uop_valid = 1'b1;
                uop_wb_en = 1'b1;
            end
        end
    end

    // Completed-swap counter: bumps when SECOND issues, wraps silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_issue_second) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_swap_sequencer.sv
// Scoreboard bench for swap_sequencer: directed steps push the expected
// per-cycle response; a monitor on the falling edge pops and compares.
module tb_swap_sequencer;

    localparam logic [5:0] SWP = 6'b111111;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode;
    logic        id_valid;
    logic        hazard_stall;
    logic        flush;

    logic        freeze, uop_valid, uop_wb_en, busy;
    logic [1:0]  swp_sel;
    logic [3:0]  uop_cmd;
    logic [15:0] swp_count;

    logic        freeze2, uop_valid2, uop_wb_en2, busy2;
    logic [1:0]  swp_sel2;
    logic [3:0]  uop_cmd2;
    logic [1:0]  swp_count2;

    int n_checks = 0;
    int n_fail   = 0;

    // kind: 0 = no micro-op, 1 = FIRST, 2 = SECOND
    typedef struct {
        int   kind;
        logic busy;
        int   cnt;
        int   cnt2;
        int   id;
    } exp_t;

    exp_t exp_q[$];
    int   step_id = 0;

    always #5 clk = ~clk;

    swap_sequencer u_dut (
        .clk(clk), .rst(rst), .opcode(opcode), .id_valid(id_valid),
        .hazard_stall(hazard_stall), .flush(flush), .freeze(freeze),
        .swp_sel(swp_sel), .uop_cmd(uop_cmd), .uop_valid(uop_valid),
        .uop_wb_en(uop_wb_en), .busy(busy), .swp_count(swp_count)
    );

    swap_sequencer #(.CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .opcode(opcode), .id_valid(id_valid),
        .hazard_stall(hazard_stall), .flush(flush), .freeze(freeze2),
        .swp_sel(swp_sel2), .uop_cmd(uop_cmd2), .uop_valid(uop_valid2),
        .uop_wb_en(uop_wb_en2), .busy(busy2), .swp_count(swp_count2)
    );

    // Drive one cycle's inputs just after the rising edge and queue the
    // hand-computed response for that cycle (cnt2 is the 2-bit counter).
    task automatic step(input logic v, input logic [5:0] op, input logic hs,
                        input logic fl, input logic r, input int kind,
                        input logic e_busy, input int cnt, input int cnt2);
        exp_t e;
        @(posedge clk);
        #1;
        id_valid     = v;
        opcode       = op;
        hazard_stall = hs;
        flush        = fl;
        rst          = r;
        e.kind = kind;
        e.busy = e_busy;
        e.cnt  = cnt;
        e.cnt2 = cnt2;
        e.id   = step_id;
        step_id++;
        exp_q.push_back(e);
    endtask

    // Monitor: compare both instances against the queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t       e;
            logic       x_fr, x_uv, x_wb;
            logic [1:0] x_sel;
            logic [3:0] x_cmd;
            e = exp_q.pop_front();
            x_fr  = (e.kind == 1);
            x_uv  = (e.kind != 0);
            x_wb  = (e.kind != 0);
            x_sel = (e.kind == 1) ? 2'b01 : (e.kind == 2) ? 2'b10 : 2'b00;
            x_cmd = (e.kind == 1) ? 4'b1100 : (e.kind == 2) ? 4'b1101 : 4'b0000;
            n_checks++;
            if ({freeze, uop_valid, uop_wb_en, swp_sel, uop_cmd, busy} !==
                {x_fr, x_uv, x_wb, x_sel, x_cmd, e.busy} ||
                swp_count !== 16'(e.cnt)) begin
                n_fail++;
                $display("FAIL step%0d outputs: got fr=%b uv=%b wb=%b sel=%b cmd=%b busy=%b cnt=%0d, want fr=%b uv=%b wb=%b sel=%b cmd=%b busy=%b cnt=%0d",
                         e.id, freeze, uop_valid, uop_wb_en, swp_sel, uop_cmd, busy, swp_count,
                         x_fr, x_uv, x_wb, x_sel, x_cmd, e.busy, e.cnt);
            end
            n_checks++;
            if ({freeze2, uop_valid2, uop_wb_en2, swp_sel2, uop_cmd2, busy2} !==
                {x_fr, x_uv, x_wb, x_sel, x_cmd, e.busy} ||
                swp_count2 !== 2'(e.cnt2)) begin
                n_fail++;
                $display("FAIL step%0d cnt2-instance: got fr=%b cmd=%b busy=%b cnt=%0d, want fr=%b cmd=%b busy=%b cnt=%0d",
                         e.id, freeze2, uop_cmd2, busy2, swp_count2, x_fr, x_cmd, e.busy, e.cnt2);
            end
        end
    end

    initial begin
        rst = 1'b1; opcode = 6'd0; id_valid = 1'b0; hazard_stall = 1'b0; flush = 1'b0;

        // Reset: outputs zero even with a SWP presented.
        step(1, SWP, 0, 0, 1, 0, 0, 0, 0);
        step(0, 6'd0, 0, 0, 1, 0, 0, 0, 0);

        // Plain SWP: FIRST at T, SECOND at T+1, idle at T+2.
        step(1, SWP, 0, 0, 0, 1, 0, 0, 0);
        step(1, SWP, 0, 0, 0, 2, 1, 0, 0);
        step(0, 6'd0, 0, 0, 0, 0, 0, 1, 1);

        // Hazard at detect for 2 cycles, then FIRST/SECOND.
        step(1, SWP, 1, 0, 0, 0, 0, 1, 1);
        step(1, SWP, 1, 0, 0, 0, 1, 1, 1);
        step(1, SWP, 0, 0, 0, 1, 1, 1, 1);
        step(1, SWP, 0, 0, 0, 2, 1, 1, 1);
        step(0, 6'd0, 0, 0, 0, 0, 0, 2, 2);

        // Flush during SECOND: no second micro-op, count unchanged.
        step(1, SWP, 0, 0, 0, 1, 0, 2, 2);
        step(1, SWP, 0, 1, 0, 0, 1, 2, 2);
        step(0, 6'd0, 0, 0, 0, 0, 0, 2, 2);

        // Hazard during SECOND: held one cycle, then issued.
        step(1, SWP, 0, 0, 0, 1, 0, 2, 2);
        step(1, SWP, 1, 0, 0, 0, 1, 2, 2);
        step(1, SWP, 0, 0, 0, 2, 1, 2, 2);
        step(0, 6'd0, 0, 0, 0, 0, 0, 3, 3);

        // HOLD_FIRST with flush and hazard together: flush wins.
        step(1, SWP, 1, 0, 0, 0, 0, 3, 3);
        step(1, SWP, 1, 1, 0, 0, 1, 3, 3);
        step(0, 6'd0, 0, 0, 0, 0, 0, 3, 3);
        // Flush at detect: SWP ignored.
        step(1, SWP, 0, 1, 0, 0, 0, 3, 3);
        step(0, 6'd0, 0, 0, 0, 0, 0, 3, 3);

        // Three back-to-back SWPs; 2-bit counter wraps 3 -> 0.
        step(1, SWP, 0, 0, 0, 1, 0, 3, 3);
        step(1, SWP, 0, 0, 0, 2, 1, 3, 3);
        step(1, SWP, 0, 0, 0, 1, 0, 4, 0);
        step(1, SWP, 0, 0, 0, 2, 1, 4, 0);
        step(1, SWP, 0, 0, 0, 1, 0, 5, 1);
        step(1, SWP, 0, 0, 0, 2, 1, 5, 1);
        step(0, 6'd0, 0, 0, 0, 0, 0, 6, 2);

        // Non-SWP opcodes and an invalid SWP: no effect.
        step(1, 6'b000001, 0, 0, 0, 0, 0, 6, 2);
        step(1, 6'b100100, 0, 0, 0, 0, 0, 6, 2);
        step(0, SWP, 0, 0, 0, 0, 0, 6, 2);

        // Opcode ignored in SECOND.
        step(1, SWP, 0, 0, 0, 1, 0, 6, 2);
        step(0, 6'b000001, 0, 0, 0, 2, 1, 6, 2);
        step(0, 6'd0, 0, 0, 0, 0, 0, 7, 3);

        // Reset asserted mid-cycle during SECOND: immediate zero, no resume.
        step(1, SWP, 0, 0, 0, 1, 0, 7, 3);
        step(1, SWP, 0, 0, 1, 0, 0, 0, 0);
        step(0, 6'd0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 6'd0, 0, 0, 0, 0, 0, 0, 0);

        @(posedge clk);
        @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Bound on total run time.
    initial begin
        #100000;
        $display("FAIL timeout: got no completion, want completion");
        $fatal(1, "timeout");
    end

endmodule
